// File: rtl/period_decode_pwm4_if.sv
// Settings and status bundle between the Nios II PIO exports and the
// four-channel PWM block. The master drives period/duty words and restart;
// the slave (PWM block) returns the waveforms, wrap ticks and active flags.
interface period_decode_pwm4_if #(parameter int WIDTH = 28);
  logic [WIDTH-1:0] period1, period2, period3, period4;
  logic [WIDTH-1:0] decode1, decode2, decode3, decode4;
  logic             restart;
  logic [3:0]       pwm_out;
  logic [3:0]       tick;
  logic [3:0]       active;

  modport master (
    output period1, period2, period3, period4,
    output decode1, decode2, decode3, decode4,
    output restart,
    input  pwm_out, tick, active
  );

  modport slave (
    input  period1, period2, period3, period4,
    input  decode1, decode2, decode3, decode4,
    input  restart,
    output pwm_out, tick, active
  );
endinterface

// File: rtl/period_decode_pwm4.sv
// Four independent double-buffered PWM channels. Each channel latches its
// period/duty words only at its own period boundary (or on restart), so a
// software write never tears a period in progress.

// One PWM channel: counter, shadow period/duty, registered compare outputs.
module pwm_lane #(parameter int WIDTH = 28) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] decode,
  output logic             pwm,
  output logic             tick,
  output logic             active
);
  logic [WIDTH-1:0] cnt, per_sh, dec_sh;
  logic             enabled, at_wrap, load;

  // per_sh-1 wraps to all-ones when per_sh==0; that case is caught by
  // 'enabled' before at_wrap is ever used.
  assign enabled = (per_sh != '0);
  assign at_wrap = (cnt == per_sh - WIDTH'(1));
  assign load    = !enabled || at_wrap || restart;
  assign active  = enabled;

  // Counter and shadow registers: reload at the boundary, count otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      per_sh <= '0;
      dec_sh <= '0;
    end else if (load) begin
      cnt    <= '0;
      per_sh <= period;
      dec_sh <= decode;
    end else begin
      cnt    <= cnt + WIDTH'(1);
    end
  end

  // Registered compare: outputs lag the counter state by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm  <= 1'b0;
      tick <= 1'b0;
    end else begin
      pwm  <= enabled && (cnt < dec_sh) && !restart;
      tick <= enabled && at_wrap && !restart;
    end
  end
endmodule

module period_decode_pwm4 #(parameter int WIDTH = 28) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  period_decode_pwm4_if.slave  bus
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][WIDTH-1:0] per_in, dec_in;
  logic [NUM_LANES-1:0]            pwm_w, tick_w, act_w;

  assign per_in = {bus.period4, bus.period3, bus.period2, bus.period1};
  assign dec_in = {bus.decode4, bus.decode3, bus.decode2, bus.decode1};

  assign bus.pwm_out = pwm_w;
  assign bus.tick    = tick_w;
  assign bus.active  = act_w;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pwm_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk_clk),
      .rst     (reset_reset),
      .restart (bus.restart),
      .period  (per_in[i]),
      .decode  (dec_in[i]),
      .pwm     (pwm_w[i]),
      .tick    (tick_w[i]),
      .active  (act_w[i])
    );
  end
endmodule

// File: tb/tb_period_decode_pwm4.sv
// Directed bench for period_decode_pwm4. A second, 8-bit instance exercises
// the maximum-period wrap (2^W-1) in a practical number of cycles.
module tb_period_decode_pwm4;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  period_decode_pwm4_if #(.WIDTH(28)) bus ();
  period_decode_pwm4_if #(.WIDTH(8))  bus8 ();

  period_decode_pwm4 #(.WIDTH(28)) dut (
    .clk_clk (clk), .reset_reset (rst), .bus (bus)
  );
  period_decode_pwm4 #(.WIDTH(8)) dut8 (
    .clk_clk (clk), .reset_reset (rst), .bus (bus8)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int n, input logic [27:0] p, input logic [27:0] d);
    case (n)
      1: begin bus.period1 = p; bus.decode1 = d; end
      2: begin bus.period2 = p; bus.decode2 = d; end
      3: begin bus.period3 = p; bus.decode3 = d; end
      default: begin bus.period4 = p; bus.decode4 = d; end
    endcase
  endtask

  task automatic clear_all();
    for (int n = 1; n <= 4; n++) set_ch(n, 28'd0, 28'd0);
  endtask

  // Two reset cycles (outputs must be 0), release, then step through the
  // load cycle so the caller sits just after start-up cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    chk("rst_pwm", {28'd0, bus.pwm_out}, 32'd0);
    chk("rst_tick", {28'd0, bus.tick}, 32'd0);
    chk("rst_active", {28'd0, bus.active}, 32'd0);
    rst = 1'b0;
    step();
    chk("load_pwm", {28'd0, bus.pwm_out}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.restart = 1'b0;
    bus8.restart = 1'b0;
    clear_all();
    bus8.period1 = '0; bus8.decode1 = '0;
    bus8.period2 = '0; bus8.decode2 = '0;
    bus8.period3 = '0; bus8.decode3 = '0;
    bus8.period4 = '0; bus8.decode4 = '0;

    // Channel 1: P=10, D=3 -> 3 high / 7 low from cycle 2, tick every 10.
    set_ch(1, 28'd10, 28'd3);
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step();
      chk("c1_pwm", {31'd0, bus.pwm_out[0]}, {31'd0, (k % 10) < 3});
      chk("c1_tick", {31'd0, bus.tick[0]}, {31'd0, (k % 10) == 9});
    end
    chk("c1_active", {28'd0, bus.active}, 32'h1);

    // Channel 2: P=8, D=4, rewritten mid-period to P=5, D=1.
    clear_all();
    set_ch(2, 28'd8, 28'd4);
    do_reset();
    for (int k = 0; k < 23; k++) begin
      if (k == 2) set_ch(2, 28'd5, 28'd1);
      step();
      if (k < 8) begin
        chk("c2_old_pwm", {31'd0, bus.pwm_out[1]}, {31'd0, k < 4});
        chk("c2_old_tick", {31'd0, bus.tick[1]}, {31'd0, k == 7});
      end else begin
        chk("c2_new_pwm", {31'd0, bus.pwm_out[1]}, {31'd0, ((k - 8) % 5) == 0});
        chk("c2_new_tick", {31'd0, bus.tick[1]}, {31'd0, ((k - 8) % 5) == 4});
      end
    end

    // Channel 3: P=6 with corner duties 0, 6, 100.
    for (int t = 0; t < 3; t++) begin
      logic [27:0] d;
      d = (t == 0) ? 28'd0 : (t == 1) ? 28'd6 : 28'd100;
      clear_all();
      set_ch(3, 28'd6, d);
      do_reset();
      for (int k = 0; k < 12; k++) begin
        step();
        chk("c3_pwm", {31'd0, bus.pwm_out[2]}, {31'd0, t != 0});
        chk("c3_tick", {31'd0, bus.tick[2]}, {31'd0, (k % 6) == 5});
      end
    end

    // Channel 4: P=1, D=1 -> constant high and tick; then disable.
    clear_all();
    set_ch(4, 28'd1, 28'd1);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("c4_pwm", {31'd0, bus.pwm_out[3]}, 32'd1);
      chk("c4_tick", {31'd0, bus.tick[3]}, 32'd1);
    end
    chk("c4_active", {31'd0, bus.active[3]}, 32'd1);
    set_ch(4, 28'd0, 28'd1);
    step();
    chk("c4_dis_pwm_last", {31'd0, bus.pwm_out[3]}, 32'd1);
    chk("c4_dis_tick_last", {31'd0, bus.tick[3]}, 32'd1);
    chk("c4_dis_active", {31'd0, bus.active[3]}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("c4_off_pwm", {31'd0, bus.pwm_out[3]}, 32'd0);
      chk("c4_off_tick", {31'd0, bus.tick[3]}, 32'd0);
      chk("c4_off_active", {31'd0, bus.active[3]}, 32'd0);
    end

    // Restart phase alignment: P=7,9,11,13, D=2,3,4,5.
    set_ch(1, 28'd7, 28'd2);
    set_ch(2, 28'd9, 28'd3);
    set_ch(3, 28'd11, 28'd4);
    set_ch(4, 28'd13, 28'd5);
    do_reset();
    for (int k = 0; k < 20; k++) step();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    chk("rs_pwm_zero", {28'd0, bus.pwm_out}, 32'h0);
    chk("rs_tick_zero", {28'd0, bus.tick}, 32'h0);
    step();
    chk("rs_pwm_aligned", {28'd0, bus.pwm_out}, 32'hF);
    step();
    chk("rs_pwm_c1", {28'd0, bus.pwm_out}, 32'hF);
    step();
    chk("rs_pwm_c2", {28'd0, bus.pwm_out}, 32'hE);
    step();
    chk("rs_pwm_c3", {28'd0, bus.pwm_out}, 32'hC);
    step();
    chk("rs_pwm_c4", {28'd0, bus.pwm_out}, 32'h8);
    step();
    chk("rs_pwm_c5", {28'd0, bus.pwm_out}, 32'h0);
    step();
    chk("rs_tick_c1", {28'd0, bus.tick}, 32'h1);

    // Maximum period on the 8-bit instance: P=255, D=128, two periods.
    clear_all();
    bus8.period1 = 8'd255;
    bus8.decode1 = 8'd128;
    do_reset();
    for (int k = 0; k < 510; k++) begin
      step();
      chk("max_pwm", {31'd0, bus8.pwm_out[0]}, {31'd0, (k % 255) < 128});
      chk("max_tick", {31'd0, bus8.tick[0]}, {31'd0, (k % 255) == 254});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/period_decode_pwm4.md
# period_decode_pwm4

Four-channel PWM generator that consumes the period and duty words the Nios II system drives on its `period1..4` and `decode1..4` PIO exports and turns each pair into a periodic pulse train. It sits outside the Qsys system, on the same system clock. It double-buffers each channel's settings so that a software write takes effect only at that channel's next period boundary. A per-channel wrap tick and a global restart input are provided for phase alignment.

## Interface

- `WIDTH`, default 28: width of period, duty and counter words (matches the PIO export width).
- `clk_clk`  input  1  system clock; all logic on the rising edge.
- `reset_reset`  input  1  synchronous, active-high reset.
- `period1` … `period4`  input  WIDTH each  channel period in clocks; 0 disables the channel.
- `decode1` … `decode4`  input  WIDTH each  channel high time in clocks (duty compare value).
- `restart`  input  1  synchronous restart of all channels (phase align).
- `pwm_out`  output  4  bit n-1 = channel n waveform; registered.
- `tick`  output  4  bit n-1 = one-cycle pulse at channel n period wrap; registered.
- `active`  output  4  bit n-1 = channel n shadow period is non-zero (combinational from registers).

## Operation

- Per-channel state: `cnt` (WIDTH), shadow `per_sh` (WIDTH), shadow `dec_sh` (WIDTH), plus the `pwm_out` and `tick` flops.
- Reset (`reset_reset`=1): all `cnt`, `per_sh`, `dec_sh`, `pwm_out` and `tick` are 0. Therefore `active`=0.
- Load condition L per channel: `per_sh`==0 OR `cnt`==`per_sh`-1 OR `restart`=1.
- Each cycle when L holds: `per_sh`<=periodN, `dec_sh`<=decodeN, `cnt`<=0.
- Each cycle when L does not hold: `cnt`<=`cnt`+1 and the shadows hold their values.
- The inputs are sampled only under L. Changes to the inputs mid-period are ignored until the boundary; no tearing between period and duty.
- `pwm_out`N <= (`per_sh`!=0) AND (`cnt` < `dec_sh`) AND NOT `restart`. The comparison is unsigned and full-width.
- `tick`N <= (`per_sh`!=0) AND (`cnt`==`per_sh`-1) AND NOT `restart`.
- Duty boundaries:
  - `dec_sh`=0 gives a constant low output.
  - `dec_sh`>=`per_sh` gives a constant high output while the channel is active.
- `per_sh`=1: `cnt` stays 0, `tick` is 1 every cycle, and `pwm_out`=(`dec_sh`>=1).
- Disabling: writing periodN=0 takes effect at the next wrap. After that, `pwm_out`=0 and `tick`=0, and the channel reloads every cycle.
- `restart` overrides wrap and count on all channels in the same cycle. Reset overrides `restart`.
- The channels are fully independent; there are no shared counters.

## Timing

- `pwm_out` and `tick` lag the counter state by exactly 1 clock (registered compare).
- Start-up after reset release, with inputs P>0, D already stable:
  - cycle 0: load, because `per_sh`=0.
  - cycle 1: `per_sh`=P, `cnt`=0.
  - from cycle 2: `pwm_out` is high for min(D,P) cycles, then low for the rest, repeating every P cycles.
- `tick` is high in the cycle after `cnt`=P-1. It coincides with the last output cycle of the previous period's shifted window, i.e. the cycle before the new period's first output cycle.
- A new setting written at cycle t takes effect in the output at most P_old+1 cycles later.
- `restart` asserted at cycle t:
  - `pwm_out`=0 and `tick`=0 at t+1.
  - `cnt`=0 with new shadows at t+1.
  - First output of the new period appears at t+2 on all channels simultaneously.
- Reset mid-period: all outputs are 0 in the cycle after reset is sampled. Start-up then proceeds as above once reset is released.
- Wrap arithmetic never overflows, because `cnt` is bounded by `per_sh`-1 <= 2^WIDTH-2.

## Test plan

- Reset, then period1=10, decode1=3 → `pwm_out[0]` is high for 3 cycles and low for 7, starting 2 cycles after reset release. `tick[0]` pulses every 10 cycles.
- Channel 2 at P=8, D=4; at `cnt`=2 write period2=5, decode2=1 → the current period completes as 4 high / 4 low, then the output is 1 high / 4 low with no intermediate glitch.
- Corner duties on channel 3, P=6: D=0 → constant low. D=6 and D=100 → constant high. `tick` still pulses every 6 cycles.
- P=1, D=1 on channel 4 → `pwm_out[3]`=1 and `tick[3]`=1 continuously. Set period4=0 → both go low after the next wrap, and `active[3]`=0.
- Channels at P=7, 9, 11, 13 running free; assert `restart` for one cycle → all `pwm_out` and `tick` are 0 the next cycle, and all four rising edges are aligned on the following cycle.
- P=2^28-1, D=2^27 on channel 1, run for 2 periods (or force `cnt` near the wrap) → there is no counter overflow, the wrap occurs at `cnt`=2^28-2, and the duty is exact.
